mux8_3to1_arb: RTL
==================

MUX8_3TO1_ARB -- requirements
Module: mux8_3to1_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of every source and of the output.
REQ-002 Port CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port RST_N  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Ports REQ1, REQ2, REQ3  input  1 each  SHALL be the source requests; source n has data pending.
REQ-005 Ports I1, I2, I3  input  WIDTH each  SHALL be the source data, valid while the matching REQn is high.
REQ-006 Ports GNT1, GNT2, GNT3  output  1 each  SHALL be the grants; GNTn high means In is captured at this edge.
REQ-007 Port Q  output  WIDTH  SHALL be the registered merged data.
REQ-008 Port Q_VALID  output  1  SHALL mean that Q holds an unconsumed word.
REQ-009 Port Q_SEL  output  2  SHALL give the origin of Q: 01 = source 1, 10 = source 2, 11 = source 3, 00 = none. These codes match the select codes of the 8-bit 1-to-3 demux.
REQ-010 Port Q_READY  input  1  SHALL mean that the consumer accepts Q at this edge.

Function
REQ-011 The output register SHALL have two states: EMPTY (Q_VALID=0) and FULL (Q_VALID=1).
REQ-012 LOAD SHALL be defined as (!Q_VALID || Q_READY).
REQ-013 When LOAD is true and any REQn is high, the block SHALL pick one winner n, assert GNTn combinationally, and at the edge capture In into Q, set Q_SEL to code n, and set Q_VALID=1.
REQ-014 When LOAD is true and no REQn is high, Q_VALID SHALL go to 0 and Q_SEL to 00 at the edge; Q SHALL hold its last value.
REQ-015 When Q_VALID=1 and Q_READY=0, Q, Q_SEL and Q_VALID SHALL hold, and all GNTn SHALL stay 0.
REQ-016 At most one GNTn SHALL be high in any cycle; GNTn SHALL never be high while REQn is low.
REQ-017 A source SHALL hold REQn and In stable until it sees GNTn, and SHALL drop REQn the next cycle unless it has another word. The block SHALL NOT check for violations of this rule.
REQ-018 Latency SHALL be one cycle: a request granted in cycle N appears on Q/Q_VALID after edge N.
REQ-019 With Q_READY held at 1 and requests pending, the block SHALL sustain one word per cycle.
REQ-020 Round-robin arbitration SHALL search from the source after LAST (the last granted index) in the order 1, 2, 3, 1, ...; LAST SHALL update only on a grant.
REQ-021 If only one source requests, it SHALL be granted every LOAD cycle, whatever the value of LAST.
REQ-022 When a Q_READY edge pops Q and a grant in the same cycle loads a new word, Q_VALID SHALL stay 1 and no bubble SHALL be inserted.

Reset
REQ-023 When RST_N is low, the block SHALL asynchronously set Q=0, Q_VALID=0, Q_SEL=00 and LAST=3, so that source 1 has first priority.
REQ-024 While RST_N is low, all GNTn SHALL be 0.
REQ-025 A reset during FULL SHALL discard the held word, and no grant SHALL be issued for it.
REQ-026 After RST_N deasserts, the first LOAD edge SHALL be the first edge that can grant.

Configuration
REQ-027 The block SHALL support macro MUX8_FIXED_PRIORITY_EN.
REQ-028 When MUX8_FIXED_PRIORITY_EN is defined, arbitration SHALL be fixed priority 1 > 2 > 3, and LAST SHALL be absent or unused.
REQ-029 When MUX8_FIXED_PRIORITY_EN is undefined, arbitration SHALL be round-robin per REQ-020.
REQ-030 All other behaviour SHALL be identical with and without MUX8_FIXED_PRIORITY_EN.

Verification
REQ-031 Bench SHALL cover reset: RST_N=0 mid-stream with Q_VALID=1 -> Q=00000000, Q_VALID=0, Q_SEL=00 immediately, with no clock edge needed.
REQ-032 Bench SHALL cover a single source: I1=5, REQ1=1, Q_READY=1 -> GNT1=1 and, after the edge, Q=00000101, Q_SEL=01, Q_VALID=1.
REQ-033 Bench SHALL cover round-robin: REQ1=REQ2=REQ3=1 held with I1=5, I2=15, I3=255 and Q_READY=1 -> Q_SEL sequence 01, 10, 11, 01 and Q sequence 5, 15, 255, 5.
REQ-034 Bench SHALL cover fixed priority (macro defined): the same stimulus as REQ-033 -> Q_SEL=01 on every cycle.
REQ-035 Bench SHALL cover backpressure: Q holding 15 with Q_SEL=10, Q_READY=0 for 3 cycles while REQ3=1 -> Q, Q_SEL and Q_VALID hold and GNT3=0; then Q_READY=1 -> GNT3=1 and next Q=255, Q_SEL=11.
REQ-036 Bench SHALL cover drain: Q_VALID=1, no requests, Q_READY=1 -> after one edge Q_VALID=0, Q_SEL=00, and Q keeps its last value.

Source files
------------

// File: rtl/mux8_3to1_arb.sv
// ---------------------------------------------------------------------------
// mux8_3to1_arb
//
// Purpose:
//   Merges three requesting sources into one registered output word. A
//   single-entry output register (EMPTY/FULL) is refilled whenever it is
//   empty or is being consumed in the same cycle. One winner is picked among
//   the requesting sources, granted combinationally, and its data is captured
//   at the next rising edge together with its origin code.
//
// Configuration:
//   MUX8_FIXED_PRIORITY_EN  defined   -> fixed priority 1 > 2 > 3
//                           undefined -> round-robin, searching from the
//                                        source after the last one granted
//
// Ports:
//   CLK             in   clock, all state updates on the rising edge
//   RST_N           in   asynchronous active-low reset
//   REQ1..REQ3      in   source n has a word pending
//   I1..I3          in   source data, valid while the matching REQn is high
//   GNT1..GNT3      out  source n is captured at this edge (one-hot or zero)
//   Q               out  registered merged data
//   Q_VALID         out  Q holds an unconsumed word
//   Q_SEL           out  origin of Q: 01/10/11 = source 1/2/3, 00 = none
//   Q_READY         in   consumer takes Q at this edge
// ---------------------------------------------------------------------------
module mux8_3to1_arb #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ1,
    input  logic             REQ2,
    input  logic             REQ3,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic             GNT1,
    output logic             GNT2,
    output logic             GNT3,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic [1:0]       Q_SEL,
    input  logic             Q_READY
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       win;
    logic [2:0]       gnt;
    logic             load;

`ifndef MUX8_FIXED_PRIORITY_EN
    logic [1:0]       last_q, last_d;
`endif

    // State register. Reset empties the output and makes source 3 the
    // "last granted" one so that source 1 is searched first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'b00;
`ifndef MUX8_FIXED_PRIORITY_EN
            last_q  <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifndef MUX8_FIXED_PRIORITY_EN
            last_q  <= last_d;
`endif
        end
    end

    // Winner selection. The result is a source code (1..3) or 0 when nobody
    // requests; it is only acted on when the output register can load.
    always_comb begin
        win = 2'd0;
`ifdef MUX8_FIXED_PRIORITY_EN
        if (REQ1)      win = 2'd1;
        else if (REQ2) win = 2'd2;
        else if (REQ3) win = 2'd3;
`else
        case (last_q)
            2'd1: begin
                if (REQ2)      win = 2'd2;
                else if (REQ3) win = 2'd3;
                else if (REQ1) win = 2'd1;
            end
            2'd2: begin
                if (REQ3)      win = 2'd3;
                else if (REQ1) win = 2'd1;
                else if (REQ2) win = 2'd2;
            end
            default: begin
                if (REQ1)      win = 2'd1;
                else if (REQ2) win = 2'd2;
                else if (REQ3) win = 2'd3;
            end
        endcase
`endif
    end

    // Next-state logic. The register loads when empty or when the held word
    // is popped this edge, so a pop and a refill in one cycle keep Q_VALID
    // high without a bubble. While full and stalled everything holds and no
    // grant is given.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        gnt     = 3'b000;
`ifndef MUX8_FIXED_PRIORITY_EN
        last_d  = last_q;
`endif
        load    = (state_q == EMPTY) || Q_READY;

        if (load) begin
            if (win != 2'd0) begin
                state_d = FULL;
                sel_d   = win;
`ifndef MUX8_FIXED_PRIORITY_EN
                last_d  = win;
`endif
                case (win)
                    2'd1: begin
                        gnt    = 3'b001;
                        data_d = I1;
                    end
                    2'd2: begin
                        gnt    = 3'b010;
                        data_d = I2;
                    end
                    default: begin
                        gnt    = 3'b100;
                        data_d = I3;
                    end
                endcase
            end else begin
                state_d = EMPTY;
                sel_d   = 2'b00;
            end
        end
    end

    // Grants are masked by reset so nothing is granted while RST_N is low,
    // even though the combinational search still sees live requests.
    assign GNT1    = gnt[0] & RST_N;
    assign GNT2    = gnt[1] & RST_N;
    assign GNT3    = gnt[2] & RST_N;
    assign Q       = data_q;
    assign Q_VALID = (state_q == FULL);
    assign Q_SEL   = sel_q;

endmodule
